// File: rtl/trig_lut_scheduler.sv
// trig_lut_scheduler
//   Accepts one trig request at a time (function select + integer angle in
//   degrees), folds the angle into a quadrant and a 0..89 reduced angle,
//   pulses the matching LUT enable for one cycle, waits LUT_LATENCY cycles
//   for the LUT result and presents it on a valid/ready response port.
//   Illegal requests (func 6/7 or angle >= 360) bypass the LUT and answer
//   with rsp_err=1 and rsp_data=0.
//
// Configuration macros:
//   DATA_WIDTH        data width, normally supplied by src/defines.v
//                     (falls back to 32 when not defined)
//   TRIG_SIGN_FIX_EN  when defined, the MSB (IEEE-754 sign) of the captured
//                     result is replaced by the sign of the function in the
//                     request's quadrant
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   req_valid     request present
//   req_ready     scheduler idle and able to accept a request
//   req_func      0 sin, 1 cos, 2 tan, 3 csc, 4 sec, 5 cot (6/7 illegal)
//   req_angle     angle in integer degrees (legal 0..359)
//   lut_en        one-hot LUT enable, bit i selects function i
//   lut_quadrant  quadrant of the request (0..3)
//   lut_angle     reduced angle (0..89)
//   lut_data      LUT result, IEEE-754 double
//   rsp_valid     response present
//   rsp_ready     consumer accepts the response
//   rsp_data      response result
//   rsp_err       request was illegal

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module trig_lut_scheduler #(
  parameter int LUT_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_func,
  input  logic [`DATA_WIDTH-1:0]   req_angle,
  output logic [5:0]               lut_en,
  output logic [1:0]               lut_quadrant,
  output logic [`DATA_WIDTH-1:0]   lut_angle,
  input  logic [2*`DATA_WIDTH-1:0] lut_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2*`DATA_WIDTH-1:0] rsp_data,
  output logic                     rsp_err
);

  localparam int DW = `DATA_WIDTH;
  // WAIT counts down from LUT_LATENCY-1 so that the capture edge falls
  // exactly LUT_LATENCY cycles after the lut_en cycle.
  localparam logic [3:0] WAIT_INIT = 4'(LUT_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, REDUCE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [2:0]    func_q;
  logic [DW-1:0] angle_q;
  logic [3:0]    wait_cnt;

  logic          legal;
  logic [1:0]    quad_c;
  logic [DW-1:0] reduced_c;
  logic [2*DW-1:0] captured;

  // Quadrant folding by comparison and subtraction; the 270..359 branch is
  // only meaningful for legal angles, illegal ones never reach the LUT.
  always_comb begin
    legal = (func_q <= 3'd5) && (angle_q < DW'(360));
    if (angle_q < DW'(90)) begin
      quad_c    = 2'd0;
      reduced_c = angle_q;
    end else if (angle_q < DW'(180)) begin
      quad_c    = 2'd1;
      reduced_c = angle_q - DW'(90);
    end else if (angle_q < DW'(270)) begin
      quad_c    = 2'd2;
      reduced_c = angle_q - DW'(180);
    end else begin
      quad_c    = 2'd3;
      reduced_c = angle_q - DW'(270);
    end
  end

`ifdef TRIG_SIGN_FIX_EN
  logic negative;

  // sin/csc negative in q2,q3; cos/sec in q1,q2; tan/cot in q1,q3.
  always_comb begin
    case (func_q)
      3'd0, 3'd3: negative = lut_quadrant[1];
      3'd1, 3'd4: negative = lut_quadrant[1] ^ lut_quadrant[0];
      default:    negative = lut_quadrant[0];
    endcase
    captured = lut_data;
    captured[2*DW-1] = negative;
  end
`else
  always_comb begin
    captured = lut_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      lut_en       <= '0;
      lut_quadrant <= '0;
      lut_angle    <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      wait_cnt     <= '0;
      func_q       <= '0;
      angle_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            func_q    <= req_func;
            angle_q   <= req_angle;
            req_ready <= 1'b0;
            state     <= REDUCE;
          end
        end
        REDUCE: begin
          if (!legal) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            state     <= RESP;
          end else begin
            lut_quadrant <= quad_c;
            lut_angle    <= reduced_c;
            lut_en       <= 6'b000001 << func_q;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          lut_en   <= '0;
          wait_cnt <= WAIT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            rsp_data  <= captured;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_lut_scheduler.sv
// Testbench for trig_lut_scheduler: directed cases followed by random
// requests, every cycle of each transaction compared against expectations
// derived from the trig rules (quadrant by division, sign by quadrant).

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_trig_lut_scheduler;

  localparam int DW  = `DATA_WIDTH;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_func;
  logic [DW-1:0]   req_angle;
  logic [5:0]      lut_en;
  logic [1:0]      lut_quadrant;
  logic [DW-1:0]   lut_angle;
  logic [2*DW-1:0] lut_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2*DW-1:0] rsp_data;
  logic            rsp_err;

  int total = 0;
  int bad   = 0;

  trig_lut_scheduler #(.LUT_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_angle(req_angle),
    .lut_en(lut_en), .lut_quadrant(lut_quadrant), .lut_angle(lut_angle),
    .lut_data(lut_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [2*DW-1:0] rand_data();
    return (2*DW)'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 128'(req_ready), 128'(1));
    checkOutput({tag, "_lut_en"}, 128'(lut_en), 128'(0));
    checkOutput({tag, "_lut_quadrant"}, 128'(lut_quadrant), 128'(0));
    checkOutput({tag, "_lut_angle"}, 128'(lut_angle), 128'(0));
    checkOutput({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
    checkOutput({tag, "_rsp_data"}, 128'(rsp_data), 128'(0));
    checkOutput({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
  endtask

  // Expected response payload from the trig sign rules.
  function automatic logic [2*DW-1:0] expected_result(input int func, input int angle,
                                                      input logic [2*DW-1:0] data);
    logic [2*DW-1:0] res;
    int q;
    bit neg;
    if (func > 5 || angle >= 360) return '0;
    res = data;
`ifdef TRIG_SIGN_FIX_EN
    q = angle / 90;
    if (func == 0 || func == 3)      neg = (q == 2 || q == 3);
    else if (func == 1 || func == 4) neg = (q == 1 || q == 2);
    else                             neg = (q == 1 || q == 3);
    res[2*DW-1] = neg;
`else
    q = 0;
    neg = 1'b0;
`endif
    return res;
  endfunction

  // One full request/response transaction, checked on every negedge.
  task automatic applyStimulus(input int func, input int angle,
                               input logic [2*DW-1:0] data, input int hold);
    bit legal;
    int q, r, rsp_edge;
    logic [5:0] en_exp;
    logic [2*DW-1:0] exp_data;
    legal    = (func <= 5) && (angle < 360);
    q        = angle / 90;
    r        = angle % 90;
    rsp_edge = legal ? LAT + 2 : 1;
    exp_data = expected_result(func, angle, data);
    en_exp   = '0;
    if (legal) en_exp[func] = 1'b1;

    @(negedge clk);
    checkOutput("req_ready_idle", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_func  = 3'(func);
    req_angle = DW'(angle);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_func  = 3'($urandom);
    req_angle = DW'($urandom);
    lut_data  = rand_data();

    for (int k = 0; k < rsp_edge; k++) begin
      @(negedge clk);
      checkOutput("rsp_valid_early", 128'(rsp_valid), 128'(0));
      checkOutput("req_ready_busy", 128'(req_ready), 128'(0));
      checkOutput("lut_en", 128'(lut_en), (k == 1) ? 128'(en_exp) : 128'(0));
      if (legal && k >= 1) begin
        checkOutput("lut_quadrant", 128'(lut_quadrant), 128'(q));
        checkOutput("lut_angle", 128'(lut_angle), 128'(r));
      end
      lut_data  = (legal && k == LAT + 1) ? data : rand_data();
      req_func  = 3'($urandom);
      req_angle = DW'($urandom);
    end

    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      lut_data = rand_data();
      checkOutput("rsp_valid", 128'(rsp_valid), 128'(1));
      checkOutput("rsp_err", 128'(rsp_err), 128'(!legal));
      checkOutput("rsp_data", 128'(rsp_data), 128'(exp_data));
      checkOutput("req_ready_resp", 128'(req_ready), 128'(0));
      checkOutput("lut_en_resp", 128'(lut_en), 128'(0));
      rsp_ready = (h == hold);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("rsp_valid_after", 128'(rsp_valid), 128'(0));
    checkOutput("req_ready_after", 128'(req_ready), 128'(1));
  endtask

  initial begin
    int f, a;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_func  = '0;
    req_angle = '0;
    lut_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("reset");

    $display("[TB] directed cases");
    applyStimulus(4, 120, rand_data(), 0);
    applyStimulus(0, 200, 64'h3FD5E3A8748A0BDD, 1);
    applyStimulus(6, 45, rand_data(), 0);
    applyStimulus(1, 360, rand_data(), 2);
    applyStimulus(2, 0, rand_data(), 0);
    applyStimulus(3, 89, rand_data(), 0);
    applyStimulus(5, 90, rand_data(), 0);
    applyStimulus(1, 359, rand_data(), 0);
    applyStimulus(2, 135, rand_data(), 5);

    $display("[TB] reset during WAIT");
    @(negedge clk);
    req_valid = 1'b1;
    req_func  = 3'd1;
    req_angle = DW'(300);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("reset_wait");
    for (int k = 0; k < 8; k++) begin
      lut_data = (k == 1) ? 64'h3FE0000000000000 : rand_data();
      @(negedge clk);
      checkOutput("no_rsp_after_reset", 128'(rsp_valid), 128'(0));
      checkOutput("idle_after_reset", 128'(req_ready), 128'(1));
      checkOutput("lut_en_after_reset", 128'(lut_en), 128'(0));
    end

    $display("[TB] random cases");
    for (int i = 0; i < 24; i++) begin
      f = $urandom_range(0, 7);
      a = ($urandom_range(0, 9) == 0) ? $urandom_range(360, 1023) : $urandom_range(0, 359);
      applyStimulus(f, a, rand_data(), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trig_lut_scheduler.md
TRIG_LUT_SCHEDULER -- requirements
Module: trig_lut_scheduler

Interface
REQ-001 SHALL have parameter LUT_LATENCY, default 1: cycles from the lut_en cycle to valid lut_data, legal range 1..15.
REQ-002 SHALL use `DATA_WIDTH from src/defines.v for all data widths.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  scheduler can accept a request.
REQ-007 SHALL have port req_func  in  3  function select: 0 sine, 1 cosine, 2 tangent, 3 cosecant, 4 secant, 5 cotangent; 6 and 7 are illegal.
REQ-008 SHALL have port req_angle  in  `DATA_WIDTH  unsigned integer degrees; legal range 0..359.
REQ-009 SHALL have port lut_en  out  6  one-hot LUT enable; bit i corresponds to req_func value i.
REQ-010 SHALL have port lut_quadrant  out  2  quadrant of the request.
REQ-011 SHALL have port lut_angle  out  `DATA_WIDTH  reduced angle, 0..89.
REQ-012 SHALL have port lut_data  in  2*`DATA_WIDTH  LUT result, IEEE-754 double.
REQ-013 SHALL have port rsp_valid  out  1  response present.
REQ-014 SHALL have port rsp_ready  in  1  consumer accepts the response.
REQ-015 SHALL have port rsp_data  out  2*`DATA_WIDTH  result.
REQ-016 SHALL have port rsp_err  out  1  request was illegal.

Function
REQ-017 SHALL implement FSM states IDLE, REDUCE, ISSUE, WAIT and RESP.
REQ-018 SHALL drive req_ready high only in IDLE; in IDLE, req_valid&req_ready latches func and angle and moves to REDUCE.
REQ-019 SHALL in REDUCE compute quadrant q = 0 for 0..89, 1 for 90..179, 2 for 180..269, 3 for 270..359, and reduced angle = angle - 90*q, using compares and subtraction only, no divider.
REQ-020 SHALL in REDUCE, for illegal func or angle >= 360, skip the LUT: go to RESP with rsp_err=1 and rsp_data=0.
REQ-021 SHALL in ISSUE assert exactly one lut_en bit for exactly one cycle, then go to WAIT.
REQ-022 SHALL hold lut_quadrant and lut_angle stable from ISSUE until the result is captured.
REQ-023 SHALL in WAIT count LUT_LATENCY cycles, capture lut_data into rsp_data, and go to RESP.
REQ-024 SHALL, for a legal request accepted at edge 0, raise rsp_valid after edge LUT_LATENCY+2; for an illegal request, after edge 1.
REQ-025 SHALL in RESP hold rsp_valid, rsp_data and rsp_err stable until rsp_valid&rsp_ready, then return to IDLE.
REQ-026 SHALL have no request/response overlap: the next request is accepted no earlier than the cycle after the response handshake.
REQ-027 SHALL keep lut_en at 0 in every state except ISSUE.
REQ-028 SHALL latch no request while not in IDLE; req_func and req_angle changes during that time have no effect.

Reset
REQ-029 SHALL on reset force state IDLE, req_ready=1, lut_en=0, lut_quadrant=0, lut_angle=0, rsp_valid=0, rsp_data=0, rsp_err=0, and clear the WAIT counter.
REQ-030 SHALL, on reset asserted mid-operation (any state), abandon the in-flight request on that edge: no response is produced and lut_data arriving later is ignored.

Configuration
REQ-031 SHALL, with macro TRIG_SIGN_FIX_EN defined, overwrite the MSB of the captured rsp_data with the quadrant sign:
- negative for sine and cosecant in q=2,3
- negative for cosine and secant in q=1,2
- negative for tangent and cotangent in q=1,3
- positive otherwise
REQ-032 SHALL, without TRIG_SIGN_FIX_EN, pass lut_data to rsp_data unchanged; REQ-031 logic is absent.

Verification
REQ-033 SHALL cover, with DATA_WIDTH=32 and LUT_LATENCY=1: func=4, angle=120 -> lut_en=6'b010000 for one cycle, lut_quadrant=1, lut_angle=30; rsp_valid after edge 3, rsp_err=0.
REQ-034 SHALL cover, with TRIG_SIGN_FIX_EN, func=0, angle=200, LUT returns 64'h3FD5E3A8748A0BDD -> rsp_data=64'hBFD5E3A8748A0BDD; without the macro, rsp_data=64'h3FD5E3A8748A0BDD.
REQ-035 SHALL cover func=6, angle=45 and, separately, func=1, angle=360 -> lut_en stays 0; rsp_valid after edge 1 with rsp_err=1, rsp_data=0.
REQ-036 SHALL cover boundary angles 0, 89, 90, 359 -> (q, lut_angle) = (0,0), (0,89), (1,0), (3,89).
REQ-037 SHALL cover rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable throughout; req_ready=0 until the cycle after the handshake.
REQ-038 SHALL cover reset asserted during WAIT with LUT_LATENCY=4 -> next cycle in IDLE, all outputs at reset values, no rsp_valid pulse.
